instr_fetch: RTL

- Fetch stage directly downstream of the program counter.
- Consumes the 11-bit PC value and issues reads to the synchronous program ROM (1-cycle read latency).
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Drives the PC's advance enable and discards stale work on a redirect (jump load).

---
 rtl/instr_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues reads to a synchronous program ROM at the
// current PC, buffers returned words and their addresses in a small prefetch
// FIFO, and presents them to decode with a valid/ready handshake. A redirect
// flushes buffered and returning work so the PC can take the jump alone.
module instr_fetch #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               redirect,
  output logic               pc_advance,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]  tag_mem  [DEPTH];

  // Return tracking: with a 1-cycle ROM, a read issued in cycle N returns
  // in cycle N+1, so one flag and one address tag cover all outstanding work.
  logic               inflight;
  logic [ADDR_W-1:0]  tag;

  logic               issue;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W:0]     occupancy;

  assign instr_valid = (count != '0);
  assign instr       = data_mem[rd_ptr];
  assign instr_pc    = tag_mem[rd_ptr];
  assign pop         = instr_valid && instr_ready;

  // A redirect outside IDLE flushes the FIFO. The word returning in the same
  // cycle belongs to the old stream and is dropped by not writing it, which
  // is all the kill handling a single-cycle ROM needs.
  assign flush       = redirect && (state != IDLE);
  assign push        = inflight && !flush;

  assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  // Issue decision. It must react in the same cycle to instr_ready and
  // redirect, so the ROM strobe and PC advance are decoded from registered
  // state rather than registered themselves.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    issue = 1'b0;
    if (state == RUN && !redirect) begin
      issue = (occupancy < DEPTH_L) || pop;
    end
  end

  assign mem_en     = issue;
  assign pc_advance = issue;
  assign mem_addr   = pc;

  // Remember whether a read is outstanding and which address it came from.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag <= pc;
      end
    end
  end

  // Prefetch FIFO: write returned words at the tail, pop at the head,
  // flush everything on a redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: storage is cleared on reset only because instr and instr_pc
      // must read as zero out of reset; with only DEPTH entries this is cheap.
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= mem_rdata;
        tag_mem[wr_ptr]  <= tag;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Run-control FSM: IDLE waits for enable, RUN issues, DRAIN lets the last
  // outstanding read land before going idle (or straight back to RUN).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight) begin
            state <= enable ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
